// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT front end: sizes, the complex
// sample type, bank status encoding and the 3-bit bit-reversal helper.
package fft_pkg;

  localparam int FFT_N    = 8;
  localparam int LOG2_N   = 3;
  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_st_t;

  function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-out bus of the FFT frame loader, plus debug taps of the
// bank status machines.
interface fft_frame_loader_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  import fft_pkg::*;

  // Both channels are valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both high; the source holds its payload stable
  // until then, and ready never depends on valid.
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            in_re;
  logic [DATA_W-1:0]            in_im;
  logic                         in_last;
  logic                         frame_valid;
  logic                         frame_ready;
  logic [FFT_N-1:0][DATA_W-1:0] frame_re;
  logic [FFT_N-1:0][DATA_W-1:0] frame_im;
  logic                         frame_err;
  logic [CNT_W-1:0]             frame_cnt;
  bank_st_t                     dbg_st0;
  bank_st_t                     dbg_st1;
  logic [LOG2_N-1:0]            dbg_idx;

  modport master (
    output in_valid, in_re, in_im, in_last, frame_ready,
    input  in_ready, frame_valid, frame_re, frame_im, frame_err, frame_cnt,
    input  dbg_st0, dbg_st1, dbg_idx
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, frame_ready,
    output in_ready, frame_valid, frame_re, frame_im, frame_err, frame_cnt,
    output dbg_st0, dbg_st1, dbg_idx
  );
endinterface

// File: rtl/fft_frame_bank.sv
// One 8-entry complex register bank with a single indexed write port and all
// slots visible in parallel.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [LOG2_N-1:0]            slot,
  input  logic [DATA_W-1:0]            wr_re,
  input  logic [DATA_W-1:0]            wr_im,
  output logic [FFT_N-1:0][DATA_W-1:0] rd_re,
  output logic [FFT_N-1:0][DATA_W-1:0] rd_im
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_re <= '0;
      rd_im <= '0;
    end else if (we) begin
      rd_re[slot] <= wr_re;
      rd_im[slot] <= wr_im;
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong loader collecting 8 complex samples into a frame for an 8-point FFT.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_frame_loader_if.slave  bus
);

  bank_st_t                     bank_st   [2];
  bank_st_t                     bank_st_n [2];
  logic                         wr_ptr, wr_ptr_n;
  logic                         rd_ptr;
  logic [LOG2_N-1:0]            idx, idx_n;
  logic                         err_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         in_ready, frame_valid;
  logic                         accept, xfer, at_last, bad, done;
  logic [LOG2_N-1:0]            slot;
  logic [FFT_N-1:0][DATA_W-1:0] rd_re [2];
  logic [FFT_N-1:0][DATA_W-1:0] rd_im [2];

  assign in_ready    = !rst && !(bank_st[0] == ST_FULL && bank_st[1] == ST_FULL);
  assign frame_valid = (bank_st[rd_ptr] == ST_FULL);
  assign accept      = bus.in_valid && in_ready;
  assign xfer        = frame_valid && bus.frame_ready;
  assign at_last     = (idx == LOG2_N'(FFT_N - 1));
  assign bad         = accept && (bus.in_last != at_last);
  assign done        = accept && bus.in_last && at_last;

`ifdef FFT_LOADER_BITREV_EN
  assign slot = bitrev3(idx);
`else
  assign slot = idx;
`endif

  // A transfer frees the read bank while the write bank may complete in the
  // same cycle; the write pointer moves as soon as its bank is FULL and the
  // other one is EMPTY, which also covers the deferred swap after a drain.
  always_comb begin
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    idx_n        = idx;
    if (xfer) bank_st_n[rd_ptr] = ST_EMPTY;
    if (accept) begin
      if (bad) begin
        bank_st_n[wr_ptr] = ST_EMPTY;
        idx_n             = '0;
      end else if (done) begin
        bank_st_n[wr_ptr] = ST_FULL;
        idx_n             = '0;
      end else begin
        bank_st_n[wr_ptr] = ST_FILLING;
        idx_n             = idx + LOG2_N'(1);
      end
    end
    wr_ptr_n = wr_ptr;
    if (bank_st_n[wr_ptr] == ST_FULL && bank_st_n[!wr_ptr] == ST_EMPTY)
      wr_ptr_n = !wr_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      idx        <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr ^ xfer;
      idx        <= idx_n;
      err_q      <= bad;
      cnt_q      <= cnt_q + CNT_W'(xfer);
    end
  end

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_ptr),
    .slot  (slot),
    .wr_re (bus.in_re),
    .wr_im (bus.in_im),
    .rd_re (rd_re[0]),
    .rd_im (rd_im[0])
  );

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_ptr),
    .slot  (slot),
    .wr_re (bus.in_re),
    .wr_im (bus.in_im),
    .rd_re (rd_re[1]),
    .rd_im (rd_im[1])
  );

  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_re    = rd_re[rd_ptr];
  assign bus.frame_im    = rd_im[rd_ptr];
  assign bus.frame_err   = err_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.dbg_st0     = bank_st[0];
  assign bus.dbg_st1     = bank_st[1];
  assign bus.dbg_idx     = idx;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: vector table, corner-case sequences and a
// randomized stream checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FW = 2 * FFT_N * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_loader_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  fft_frame_loader #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q [$];
  logic [DW-1:0] cur_re [$];
  logic [DW-1:0] cur_im [$];
  logic          exp_err = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  typedef struct {
    logic v, last, fr;
    logic [DW-1:0] re, im;
    logic e_rdy, e_fv, e_err;
    logic [CW-1:0] e_cnt;
    logic chk_data;
    logic [FW-1:0] e_data;
  } row_t;
  row_t rows [$];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int slot_of(input int n);
`ifdef FFT_LOADER_BITREV_EN
    return (n % 2) * 4 + ((n / 2) % 2) * 2 + (n / 4);
`else
    return n;
`endif
  endfunction

  // Model: collect accepted samples; a well-formed group of 8 becomes a frame.
  function automatic void model_sample(input logic last, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int n = cur_re.size();
    logic [FFT_N-1:0][DW-1:0] fr, fi;
    if (last != (n == 7)) begin
      cur_re.delete();
      cur_im.delete();
      exp_err = 1'b1;
    end else begin
      cur_re.push_back(re);
      cur_im.push_back(im);
      if (last) begin
        for (int k = 0; k < FFT_N; k++) begin
          fr[slot_of(k)] = cur_re[k];
          fi[slot_of(k)] = cur_im[k];
        end
        exp_q.push_back({fr, fi});
        cur_re.delete();
        cur_im.delete();
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur_re.delete();
    cur_im.delete();
    exp_err = 1'b0;
    exp_cnt = '0;
  endfunction

  task automatic model_check();
    check("in_ready", bus.in_ready, exp_q.size() < 2);
    check("frame_valid", bus.frame_valid, exp_q.size() > 0);
    check("frame_err", bus.frame_err, exp_err);
    check("frame_cnt", bus.frame_cnt, exp_cnt);
    if (exp_q.size() > 0) check("frame_data", {bus.frame_re, bus.frame_im}, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; checks state, drives one cycle, returns at the next falling edge.
  task automatic step(input logic v, input logic last, input logic [DW-1:0] re,
                      input logic [DW-1:0] im, input logic fr, output logic acc);
    logic xfer;
    model_check();
    bus.in_valid    = v;
    bus.in_last     = last;
    bus.in_re       = re;
    bus.in_im       = im;
    bus.frame_ready = fr;
    acc  = v && (exp_q.size() < 2);
    xfer = fr && (exp_q.size() > 0);
    if (xfer) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    exp_err = 1'b0;
    if (acc) model_sample(last, re, im);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic a;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, a);
      guard++;
    end
    check("drain_done", bus.frame_valid, 1'b0);
  endtask

  function automatic void add_row(input logic v, input logic last, input logic fr, input int re,
                                  input int im, input logic e_rdy, input logic e_fv,
                                  input logic e_err, input int e_cnt, input logic chk,
                                  input logic [FW-1:0] e_data);
    row_t r;
    r.v = v; r.last = last; r.fr = fr; r.re = DW'(re); r.im = DW'(im);
    r.e_rdy = e_rdy; r.e_fv = e_fv; r.e_err = e_err; r.e_cnt = CW'(e_cnt);
    r.chk_data = chk; r.e_data = e_data;
    rows.push_back(r);
  endfunction

  function automatic logic [FW-1:0] ramp_frame(input int base_re, input int base_im);
    logic [FFT_N-1:0][DW-1:0] fr, fi;
    for (int k = 0; k < FFT_N; k++) begin
      fr[slot_of(k)] = DW'(base_re + k);
      fi[slot_of(k)] = DW'(base_im - k);
    end
    return {fr, fi};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic a;
    int acc_n, cyc, exp_slot [FFT_N];
    logic released;
    logic [FFT_N-1:0][DW-1:0] vr;

    // Vector table: basic frame, short frame, late frame, missing last.
    for (int k = 0; k < 8; k++)
      add_row(1, k == 7, 1, k + 1, -(k + 1), 1, k == 7, 0, 0, k == 7, ramp_frame(1, -1));
    add_row(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, '0);
    for (int j = 0; j < 5; j++)
      add_row(1, j == 4, 1, 50 + j, 0, 1, 0, j == 4, 1, 0, '0);
    add_row(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, '0);
    for (int j = 0; j < 8; j++)
      add_row(1, j == 7, 0, 60 + j, 70 - j, 1, j == 7, 0, 1, j == 7, ramp_frame(60, 70));
    add_row(0, 0, 1, 0, 0, 1, 0, 0, 2, 0, '0);
    for (int j = 0; j < 8; j++)
      add_row(1, 0, 0, 80 + j, 0, 1, 0, j == 7, 2, 0, '0);
    add_row(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, '0);
    for (int j = 0; j < 8; j++)
      add_row(1, j == 7, 1, 90 + j, -90 - j, 1, j == 7, 0, 2, j == 7, ramp_frame(90, -90));
    add_row(0, 0, 1, 0, 0, 1, 0, 0, 3, 0, '0);

    bus.in_valid = 0; bus.in_last = 0; bus.in_re = '0; bus.in_im = '0; bus.frame_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_frame_valid", bus.frame_valid, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_frame_cnt", bus.frame_cnt, '0);
    check("rst_frame_data", {bus.frame_re, bus.frame_im}, '0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    for (int i = 0; i < rows.size(); i++) begin
      step(rows[i].v, rows[i].last, rows[i].re, rows[i].im, rows[i].fr, a);
      check($sformatf("row%0d_ready", i), bus.in_ready, rows[i].e_rdy);
      check($sformatf("row%0d_fv", i), bus.frame_valid, rows[i].e_fv);
      check($sformatf("row%0d_err", i), bus.frame_err, rows[i].e_err);
      check($sformatf("row%0d_cnt", i), bus.frame_cnt, rows[i].e_cnt);
      if (rows[i].chk_data)
        check($sformatf("row%0d_data", i), {bus.frame_re, bus.frame_im}, rows[i].e_data);
    end

    // Backpressure: 24 samples, frame_ready held low until both banks fill.
    acc_n = 0; cyc = 0; released = 1'b0;
    while (acc_n < 24 && cyc < 300) begin
      if (acc_n == 16 && !released) begin
        check("ready_drop_after_16", bus.in_ready, 1'b0);
        released = 1'b1;
      end
      step(1, acc_n % 8 == 7, DW'(200 + acc_n), DW'(~acc_n), released, a);
      if (a) acc_n++;
      cyc++;
    end
    check("stream24_accepted", acc_n, 24);
    drain();
    check("stream24_cnt", bus.frame_cnt, CW'(6));

    // Completion of one frame in the same cycle the previous one leaves.
    for (int k = 0; k < 8; k++) step(1, k == 7, DW'(400 + k), DW'(0), 0, a);
    for (int k = 0; k < 7; k++) step(1, 0, DW'(500 + k), DW'(600 - k), 0, a);
    check("same_cycle_ready_before", bus.in_ready, 1'b1);
    step(1, 1, DW'(507), DW'(593), 1, a);
    check("same_cycle_ready_after", bus.in_ready, 1'b1);
    check("same_cycle_fv", bus.frame_valid, 1'b1);
    check("same_cycle_cnt", bus.frame_cnt, CW'(7));
    check("same_cycle_data", {bus.frame_re, bus.frame_im}, ramp_frame(500, 600));

    // Reset with a frame pending and a partial fill in progress.
    for (int k = 0; k < 3; k++) step(1, 0, DW'(700 + k), DW'(1), 0, a);
    bus.in_valid = 0; bus.frame_ready = 0;
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_frame_valid", bus.frame_valid, 1'b0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_frame_cnt", bus.frame_cnt, '0);
    check("midrst_frame_data", {bus.frame_re, bus.frame_im}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) step(1, k == 7, DW'(300 + k), DW'(-300 - k), 0, a);
    check("post_rst_data", {bus.frame_re, bus.frame_im}, ramp_frame(300, -300));
    drain();
    check("post_rst_cnt", bus.frame_cnt, CW'(1));

    // Slot ordering of a plain ramp.
`ifdef FFT_LOADER_BITREV_EN
    exp_slot = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    exp_slot = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int k = 0; k < 8; k++) step(1, k == 7, DW'(k), DW'(0), 0, a);
    vr = bus.frame_re;
    for (int s = 0; s < FFT_N; s++)
      check($sformatf("order_slot%0d", s), vr[s], DW'(exp_slot[s]));
    drain();

    // Randomized traffic with occasional framing errors.
    for (int c = 0; c < 600; c++) begin
      logic nat, last;
      nat  = (cur_re.size() == 7);
      last = ($urandom_range(0, 19) == 0) ? !nat : nat;
      step($urandom_range(0, 3) != 0, last, DW'($urandom), DW'($urandom),
           $urandom_range(0, 2) != 0, a);
    end
    drain();
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 Parameter DATA_W, default 16, signed two's-complement width of each real and imaginary sample component.
REQ-002 Parameter CNT_W, default 16, width of the accepted-frame counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  loader can accept a sample this cycle.
REQ-007 in_re / in_im  input  DATA_W each  sample real / imaginary part.
REQ-008 in_last  input  1  marks the 8th sample of a frame.
REQ-009 frame_valid  output  1  complete 8-sample frame presented.
REQ-010 frame_ready  input  1  downstream 8-point FFT consumes the frame.
REQ-011 frame_re / frame_im  output  8 x DATA_W each  frame slots 0..7.
REQ-012 frame_err  output  1  one-cycle pulse on framing error.
REQ-013 frame_cnt  output  CNT_W  count of frames handed downstream.

Function
REQ-014 A sample transfers when in_valid and in_ready are both high; a frame transfers when frame_valid and frame_ready are both high.
REQ-015 Storage is two banks of 8 complex samples (ping-pong); the write bank fills while the other bank is presented.
REQ-016 The write index runs 0..7; an accepted sample goes to slot idx of the write bank and idx increments.
REQ-017 The bank status per bank is EMPTY -> FILLING -> FULL -> EMPTY; FULL is entered on the accepted 8th sample (idx=7 with in_last=1) and EMPTY on frame transfer.
REQ-018 When a bank goes FULL, the write pointer swaps to the other bank on the next cycle, provided that bank is EMPTY.
REQ-019 in_ready is low only when both banks are FULL; throughput is one sample per cycle while frames are drained every 8 cycles.
REQ-020 frame_valid rises the cycle after the 8th sample is accepted (latency 1 cycle), and frame_re/frame_im stay stable while frame_valid=1 and frame_ready=0.
REQ-021 Frames leave in arrival order; the read pointer toggles on each frame transfer.
REQ-022 If an 8th-sample completion and a frame transfer occur in the same cycle, both take effect, and in_ready stays high.
REQ-023 Framing error: when in_last=1 with idx<7, or in_last=0 with idx=7, the partial frame is discarded, idx returns to 0, the bank returns to EMPTY, and frame_err pulses for one cycle.
REQ-024 frame_cnt increments by 1 on each frame transfer and wraps from 2^CNT_W-1 to 0.
REQ-025 The loader performs no arithmetic; sample values pass bit-exact.

Reset
REQ-026 While rst=1, in_ready=0, frame_valid=0, frame_err=0, frame_cnt=0, frame_re/frame_im=0, idx=0, both banks EMPTY, and both pointers at bank 0.
REQ-027 in_ready goes high in the first cycle after rst deasserts.
REQ-028 A rst during a partial fill or a pending frame discards all data, and no frame_err is raised.

Configuration
REQ-029 With macro FFT_LOADER_BITREV_EN defined, the sample with arrival index n is written to slot bitrev3(n) (0,4,2,6,1,5,3,7); without the macro, it is written to slot n.
REQ-030 With FFT_LOADER_BITREV_EN defined, the write index drives frame-boundary and error checks exactly as it does without the macro.

Structure
REQ-031 A shared package fft_pkg holds FFT_N=8, LOG2_N=3, the complex sample struct typedef (re, im of DATA_W), and the bitrev3 function.
REQ-032 One sub-module, fft_frame_bank (8-entry complex register bank with write-enable and slot index), is instantiated twice.

Verification
REQ-033 Reset then 8 samples re=1..8, im=-1..-8 with in_last on the 8th, frame_ready=1 -> frame_valid one cycle after, slot k re=k+1, im=-(k+1), frame_cnt=1.
REQ-034 Continuous 24 samples with frame_ready=0 -> in_ready drops after the 16th accepted sample; release frame_ready -> frames 1, 2, 3 delivered in order, with no sample lost.
REQ-035 in_last asserted on the 5th sample -> frame_err pulses once, no frame_valid, and the next 8 well-formed samples produce a correct frame.
REQ-036 8th sample accepted in the same cycle as the previous frame's transfer -> in_ready stays 1 and the new frame is valid next cycle.
REQ-037 rst asserted after 3 samples and while a frame is pending -> all outputs zero immediately, frame_err=0, and a subsequent frame is correct.
REQ-038 FFT_LOADER_BITREV_EN defined, samples re=0..7 -> frame_re = {0,4,2,6,1,5,3,7}.
